// File: rtl/obi_req_delay_line.sv
// OBI request-channel delay line: 0..NDELAY run-time selectable register stages,
// each with full-rate req/gnt backpressure, plus occupancy and synchronous flush.

package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;
endpackage

module obi_req_delay_line
  import obi_pkg::*;
#(
  parameter int unsigned NDELAY = 2,
  // Derived width; leave at its default.
  parameter int unsigned DW     = $clog2(NDELAY + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_pipeline_i,
  input  logic [DW-1:0] delay_sel_i,
  input  obi_req_t      core_instr_req_i,
  output logic          core_instr_resp_gnt_o,
  output obi_req_t      core_instr_req_o,
  input  logic          core_instr_resp_gnt_i,
  output logic [DW-1:0] count_o,
  output logic          empty_o
);

  logic [DW-1:0]     delay_q;
  logic [DW-1:0]     entry;
  logic [DW-1:0]     delay_sat;
  logic [DW-1:0]     count_q;
  logic              passthru;
  logic              load_delay;
  logic [NDELAY-1:0] valid_q;
  logic [NDELAY-1:0] valid_d;
  logic [NDELAY-1:0] in_v;
  logic [NDELAY:0]   rdy;
  obi_req_t          data_q [NDELAY];
  obi_req_t          data_d [NDELAY];
  obi_req_t          in_p   [NDELAY];

  function automatic logic [DW-1:0] popcount(input logic [NDELAY-1:0] v);
    logic [DW-1:0] n;
    n = '0;
    for (int i = 0; i < NDELAY; i++) n = n + DW'(v[i]);
    return n;
  endfunction

  // Stages below the entry stage are bypassed; the active ones form the tail.
  assign entry     = DW'(NDELAY) - delay_q;
  assign passthru  = (delay_q == '0);
  assign delay_sat = (delay_sel_i > DW'(NDELAY)) ? DW'(NDELAY) : delay_sel_i;
  // Depth may only change when nothing is in flight, so ordering is never disturbed.
  assign load_delay = clear_pipeline_i | (empty_o & ~core_instr_req_i.req);

  always_comb begin
    rdy[NDELAY] = core_instr_resp_gnt_i;
    for (int k = NDELAY - 1; k >= 0; k--) rdy[k] = ~valid_q[k] | rdy[k+1];
  end

  // In passthrough there is no storage to flush, so the grant follows the bus directly.
  assign core_instr_resp_gnt_o = passthru ? core_instr_resp_gnt_i
                                          : (rdy[entry] & ~clear_pipeline_i);

  for (genvar k = 0; k < NDELAY; k++) begin : g_stage_in
    if (k == 0) begin : g_first
      assign in_v[k] = core_instr_req_i.req;
      assign in_p[k] = core_instr_req_i;
    end else begin : g_chain
      assign in_v[k] = (entry == DW'(k)) ? core_instr_req_i.req : valid_q[k-1];
      assign in_p[k] = (entry == DW'(k)) ? core_instr_req_i     : data_q[k-1];
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < NDELAY; k++) begin
      if (clear_pipeline_i || DW'(k) < entry) begin
        valid_d[k] = 1'b0;
      end else if (rdy[k]) begin
        valid_d[k] = in_v[k];
        if (in_v[k]) data_d[k] = in_p[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: state uses non-blocking assignments so all stages shift on the same edge.
      valid_q <= '0;
      count_q <= '0;
      delay_q <= DW'(NDELAY);
      // NOTE: the payload array is reset as well, so the bus sees all-zero fields after reset.
      for (int k = 0; k < NDELAY; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= popcount(valid_d);
      if (load_delay) delay_q <= delay_sat;
    end
  end

  always_comb begin
    core_instr_req_o     = data_q[NDELAY-1];
    core_instr_req_o.req = valid_q[NDELAY-1];
    if (passthru) core_instr_req_o = core_instr_req_i;
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule
